// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding and default widths.
package pipe_pkg;

  typedef logic [1:0] stateT;

  localparam stateT ST_EMPTY = 2'd0;
  localparam stateT ST_ONE   = 2'd1;
  localparam stateT ST_TWO   = 2'd2;

  localparam int DATA_W_DEFAULT = 112;
  localparam int CTRL_W_DEFAULT = 20;

  // All-zero control word deasserts every write/halt enable downstream.
  localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE_DEFAULT = '0;

  function automatic logic [1:0] occupancyOf(input stateT s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_TWO:  occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between an upstream stage, the skid register stage and downstream.
interface pipe_stage_skid_if #(
  parameter int DATA_W = pipe_pkg::DATA_W_DEFAULT,
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEFAULT
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // The stage itself sees the bus through the slave view.
  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipe_reg_en.sv
// Enabled register bank with asynchronous active-high reset to a parametrised value.
module pipe_reg_en #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main register feeds the outputs, skid register absorbs one
// extra entry while downstream stalls, so in_ready never depends on out_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEFAULT,
  parameter int                CTRL_W      = CTRL_W_DEFAULT,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEFAULT)
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_skid_if.slave  bus
);

  stateT       stateReg;
  stateT       stateNext;
  logic        outValidReg;
  logic        inReadyReg;
  logic [1:0]  occupancyReg;

  logic        accept;
  logic        consume;
  logic        mainLoad;
  logic        mainFromSkid;
  logic        skidLoad;

  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] mainDataD;
  logic [CTRL_W-1:0] mainCtrlD;

  assign accept  = bus.in_valid & inReadyReg;
  assign consume = outValidReg & bus.out_ready;

  always_comb begin
    stateNext    = stateReg;
    mainLoad     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    case (stateReg)
      ST_EMPTY: begin
        if (accept) begin
          mainLoad  = 1'b1;
          stateNext = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          mainLoad = 1'b1;
        end else if (accept) begin
          skidLoad  = 1'b1;
          stateNext = ST_TWO;
        end else if (consume) begin
          stateNext = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (consume) begin
          mainLoad     = 1'b1;
          mainFromSkid = 1'b1;
          stateNext    = ST_ONE;
        end
      end
      default: stateNext = ST_EMPTY;
    endcase
    // Register loads during a flush are harmless: the state forgets them.
    if (bus.flush) begin
      stateNext = ST_EMPTY;
    end
  end

  // Handshake outputs are registered from the next state, so they never see out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= ST_EMPTY;
      outValidReg  <= 1'b0;
      inReadyReg   <= 1'b1;
      occupancyReg <= 2'd0;
    end else begin
      stateReg     <= stateNext;
      outValidReg  <= (stateNext != ST_EMPTY);
      inReadyReg   <= (stateNext != ST_TWO);
      occupancyReg <= occupancyOf(stateNext);
    end
  end

  assign mainDataD = mainFromSkid ? skidData : bus.in_data;
  assign mainCtrlD = mainFromSkid ? skidCtrl : bus.in_ctrl;

  pipe_reg_en #(.WIDTH(DATA_W), .RESET_VAL('0)) uMainData (
    .clk(clk), .rst(rst), .en(mainLoad), .d(mainDataD), .q(mainData)
  );

  pipe_reg_en #(.WIDTH(CTRL_W), .RESET_VAL(CTRL_BUBBLE)) uMainCtrl (
    .clk(clk), .rst(rst), .en(mainLoad), .d(mainCtrlD), .q(mainCtrl)
  );

  pipe_reg_en #(.WIDTH(DATA_W), .RESET_VAL('0)) uSkidData (
    .clk(clk), .rst(rst), .en(skidLoad), .d(bus.in_data), .q(skidData)
  );

  pipe_reg_en #(.WIDTH(CTRL_W), .RESET_VAL(CTRL_BUBBLE)) uSkidCtrl (
    .clk(clk), .rst(rst), .en(skidLoad), .d(bus.in_ctrl), .q(skidCtrl)
  );

  assign bus.in_ready  = inReadyReg;
  assign bus.out_valid = outValidReg;
  assign bus.occupancy = occupancyReg;
  assign bus.out_data  = mainData;
  assign bus.out_ctrl  = outValidReg ? mainCtrl : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios plus a random handshake run.
module tb_pipe_stage_skid;
  localparam int DW = 112;
  localparam int CW = 20;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE('0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  entT q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
    return {4'hA, d[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = ctrlOf(d);
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: holds exactly the entries the stage should be holding.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit acc, con;
      entT e;
      con = (q.size() > 0) && bus.out_ready;
      acc = bus.in_valid && (q.size() < 2);
      e.d = bus.in_data;
      e.c = bus.in_ctrl;
      if (con) void'(q.pop_front());
      if (bus.flush) q.delete();
      else if (acc) q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the model head every cycle.
  always @(negedge clk) begin
    chk("occupancy", 128'(bus.occupancy), 128'(q.size()));
    chk("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(bus.out_valid), 128'(q.size() != 0));
    if (q.size() == 0) begin
      chk("out_ctrl_bubble", 128'(bus.out_ctrl), 128'(0));
    end else begin
      chk("out_data", 128'(bus.out_data), 128'(q[0].d));
      chk("out_ctrl", 128'(bus.out_ctrl), 128'(q[0].c));
    end
  end

  initial begin
    logic [127:0] rnd;
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    chk("reset_occupancy", 128'(bus.occupancy), 128'(0));
    chk("reset_out_data", 128'(bus.out_data), 128'(0));
    chk("reset_out_ctrl", 128'(bus.out_ctrl), 128'(0));
    step();

    // Stream 1..8 at full throughput: each visible one cycle after accept.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      step();
      chk("stream_data", 128'(bus.out_data), 128'(i));
      chk("stream_ctrl", 128'(bus.out_ctrl), 128'({4'hA, 16'(i)}));
      chk("stream_in_ready", 128'(bus.in_ready), 128'(1));
    end

    // Gap of invalid cycles: bubble control word.
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("gap_out_valid", 128'(bus.out_valid), 128'(0));
      chk("gap_bubble", 128'(bus.out_ctrl), 128'(0));
      step();
    end

    // Stall four cycles with input valid: two held, in_ready drops.
    drive(1'b1, DW'('h11), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h12), 1'b0, 1'b0);
    step();
    chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
    chk("stall_occ", 128'(bus.occupancy), 128'(2));
    drive(1'b1, DW'('h13), 1'b0, 1'b0);
    step();
    step();
    chk("stall_head", 128'(bus.out_data), 128'('h11));
    drive(1'b1, DW'('h13), 1'b1, 1'b0);
    step();
    chk("release_1", 128'(bus.out_data), 128'('h12));
    chk("release_ready", 128'(bus.in_ready), 128'(1));
    step();
    chk("release_2", 128'(bus.out_data), 128'('h13));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("release_empty", 128'(bus.out_valid), 128'(0));

    // Flush with two held and input offered.
    drive(1'b1, DW'('h21), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h22), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h23), 1'b0, 1'b1);
    step();
    chk("flush2_occ", 128'(bus.occupancy), 128'(0));
    chk("flush2_valid", 128'(bus.out_valid), 128'(0));
    chk("flush2_bubble", 128'(bus.out_ctrl), 128'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("flush2_no_leak", 128'(bus.out_valid), 128'(0));

    // Flush in ONE while an entry is accepted: that entry is discarded.
    drive(1'b1, DW'('h31), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h32), 1'b0, 1'b1);
    step();
    chk("flush1_occ", 128'(bus.occupancy), 128'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("flush1_no_leak", 128'(bus.out_valid), 128'(0));

    // Asynchronous reset with two entries held.
    drive(1'b1, DW'('h41), 1'b0, 1'b0);
    step();
    drive(1'b1, DW'('h42), 1'b0, 1'b0);
    step();
    chk("prereset_occ", 128'(bus.occupancy), 128'(2));
    #2 rst = 1'b1;
    #1;
    chk("midreset_valid", 128'(bus.out_valid), 128'(0));
    chk("midreset_ctrl", 128'(bus.out_ctrl), 128'(0));
    chk("midreset_ready", 128'(bus.in_ready), 128'(1));
    chk("midreset_occ", 128'(bus.occupancy), 128'(0));
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    #2 rst = 1'b0;
    step();

    // Random handshake traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'($urandom_range(0, 1)), rnd[DW-1:0], 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    step();
    step();
    chk("drain_empty", 128'(bus.out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
